nib_acc: RTL and testbench

NIB_ACC -- requirements
Module: nib_acc

---
 rtl/nib_acc.sv | 143 ++++++++++++++
 tb/tb_nib_acc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nib_acc.sv
// nib_acc: nibble-serial accumulator.
// Each accepted 4-bit operand is added into an ACC_W-bit accumulator one
// nibble per cycle (ADD state, exactly NIB cycles), then DONE pulses for one
// cycle. Carry out of the top nibble sets a sticky overflow flag and the
// accumulator wraps modulo 2^ACC_W.
module nib_acc #(
  parameter int NIB = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        in_data,
  output logic              in_ready,
  input  logic              clr,
  output logic [4*NIB-1:0]  acc,
  output logic              ovf,
  output logic              busy,
  output logic              done
);

  localparam int ACC_W = 4 * NIB;
  localparam int K_W   = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [K_W-1:0]   r_k;
  logic             r_carry;
  logic [3:0]       r_op;

  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_nib;
  logic [3:0]       w_addend;
  logic [4:0]       w_sum;

  // clr has priority over an offered operand; no accept outside IDLE.
  assign in_ready = (r_state == S_IDLE) && !clr;
  assign w_accept = in_ready && in_valid;
  assign w_last   = (r_k == K_W'(NIB - 1));

  assign acc  = r_acc;
  assign ovf  = r_ovf;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  // Select the current nibble, the addend (operand only on nibble 0) and add with carry.
  always_comb begin
    w_nib = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (r_k == K_W'(i)) begin
        w_nib = r_acc[i*4 +: 4];
      end else begin
        w_nib = w_nib;
      end
    end
    if (r_k == '0) begin
      w_addend = r_op;
    end else begin
      w_addend = 4'h0;
    end
    w_sum = {1'b0, w_nib} + {1'b0, w_addend} + {4'h0, r_carry};
  end

  // Next-state logic: IDLE -> ADD on accept, ADD for NIB cycles, DONE for one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_ADD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADD: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ADD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: clear/accept in IDLE, one nibble write-back per ADD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_op    <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end else if (in_valid) begin
            r_op    <= in_data;
            r_k     <= '0;
            r_carry <= 1'b0;
          end
        end
        S_ADD: begin
          for (int i = 0; i < NIB; i++) begin
            if (r_k == K_W'(i)) begin
              r_acc[i*4 +: 4] <= w_sum[3:0];
            end
          end
          r_carry <= w_sum[4];
          r_k     <= r_k + K_W'(1);
          if (w_last && w_sum[4]) begin
            r_ovf <= 1'b1;
          end
        end
        default: begin
          r_k <= r_k;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nib_acc.sv
// Self-checking bench for nib_acc (NIB=2): table of operands with expected
// results, plus hand-written clear, back-to-back and reset-abort sequences.
// Expected results go into a scoreboard queue at the accept edge and are
// compared when done is seen.
module tb_nib_acc;

  localparam int NIB = 2;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       clr;
  logic [7:0] acc;
  logic       ovf;
  logic       busy;
  logic       done;

  nib_acc #(.NIB(NIB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .clr      (clr),
    .acc      (acc),
    .ovf      (ovf),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [7:0] acc;
    logic       ovf;
    int         cyc;
  } sb_t;

  typedef struct {
    logic [3:0] data;
    logic [7:0] exp_acc;
    logic       exp_ovf;
  } vec_t;

  sb_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic o, input int c);
    sb_t e;
    e.acc = a;
    e.ovf = o;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("done_acc", {24'h0, acc}, {24'h0, e.acc});
        chk("done_ovf", {31'h0, ovf}, {31'h0, e.ovf});
        chk("done_latency", cyc, e.cyc);
      end
    end
  end

  // Offer one operand, wait (bounded) for acceptance and record the expectation.
  task automatic send(input logic [3:0] d, input logic [7:0] ea, input logic eo);
    int g;
    g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && g < 40) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      push_exp(ea, eo, cyc + NIB);
      in_valid = 1'b0;
    end
  endtask

  // Wait until the DUT is idle and every expectation has been consumed.
  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy || sb.size() != 0) && g < 50) begin
      @(negedge clk);
      #2;
      g++;
    end
    if (busy || sb.size() != 0) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  vec_t vecs[4];

  initial begin
    int n_acc;
    int prev;
    int g;

    vecs[0] = '{data: 4'hF, exp_acc: 8'h0F, exp_ovf: 1'b0};
    vecs[1] = '{data: 4'h1, exp_acc: 8'h10, exp_ovf: 1'b0};
    vecs[2] = '{data: 4'hA, exp_acc: 8'h1A, exp_ovf: 1'b0};
    vecs[3] = '{data: 4'h7, exp_acc: 8'h21, exp_ovf: 1'b0};

    // Reset: operand offered during reset must not be accepted.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'h9;
    clr      = 1'b0;
    #1;
    chk("rst_acc", {24'h0, acc}, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_accept", {31'h0, busy}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Build acc=0F, then reset during the second ADD cycle of a +0 operation.
    send(4'hF, 8'h0F, 1'b0);
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'h0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("abort_pre_busy", {31'h0, busy}, 32'h1);
    chk("abort_pre_acc", {24'h0, acc}, 32'h0F);
    rst_n = 1'b0;
    #1;
    chk("abort_acc", {24'h0, acc}, 32'h0);
    chk("abort_ovf", {31'h0, ovf}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", {31'h0, busy}, 32'h0);
    chk("abort_stays_zero", {24'h0, acc}, 32'h0);

    // Table-driven operands from a cleared accumulator.
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].data, vecs[i].exp_acc, vecs[i].exp_ovf);
    end
    wait_idle();

    // clr wins over in_valid; next cycle with clr low the operand is accepted.
    @(negedge clk);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h5;
    #1;
    chk("clr_in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    chk("clr_acc", {24'h0, acc}, 32'h0);
    chk("clr_ovf", {31'h0, ovf}, 32'h0);
    chk("clr_not_accepted", {31'h0, busy}, 32'h0);
    clr = 1'b0;
    #1;
    chk("post_clr_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    push_exp(8'h05, 1'b0, cyc + NIB);
    in_valid = 1'b0;
    wait_idle();

    // Clear, then 17 x F reaches FF; +1 wraps with ovf; +2 keeps ovf.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      send(4'hF, 8'(i * 15), 1'b0);
    end
    send(4'h1, 8'h00, 1'b1);
    send(4'h2, 8'h02, 1'b1);
    wait_idle();
    chk("ovf_sticky_idle", {31'h0, ovf}, 32'h1);

    // Clear, then in_valid held continuously: accepts every NIB+2 cycles.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr2_ovf", {31'h0, ovf}, 32'h0);
    in_valid = 1'b1;
    in_data  = 4'h3;
    n_acc = 0;
    prev  = -1;
    g     = 0;
    while (n_acc < 3 && g < 40) begin
      #1;
      if (busy) chk("busy_in_ready", {31'h0, in_ready}, 32'h0);
      if (in_ready) begin
        n_acc++;
        push_exp(8'(3 * n_acc), 1'b0, cyc + 1 + NIB);
        if (prev >= 0) chk("accept_spacing", cyc - prev, NIB + 2);
        prev = cyc;
      end
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", n_acc, 3);
    wait_idle();
    chk("final_acc", {24'h0, acc}, 32'h09);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
